spi_ram_slave: RTL and testbench
================================

Name: spi_ram_slave

Overview:
- Synthesisable, clocked successor to the behavioural SPI RAM model; serves as on-chip or FPGA-side program/data RAM for the SPI CPU.
- SPI mode 0 slave, oversampled in the `clk` domain, with a parametrised address length and memory depth.
- Supports READ (0x03) and WRITE (0x02), both with sequential burst and wrap-around.
- Unknown opcodes are flagged.

Parameters:
- MEM_BYTES, 256: memory depth in bytes; must be a power of two, 2..65536.
- ADDR_BYTES, 2: number of address bytes following the opcode (1..3).
- SYNC_STAGES, 2: synchroniser flops on cs_n, sck and mosi (>=2).

Ports:
- clk  input  1  system clock; must be >= 8x the SCK frequency.
- rst  input  1  synchronous, active-high reset.
- cs_n  input  1  SPI chip select, active low, asynchronous to clk.
- sck  input  1  SPI clock, mode 0 (idles low), asynchronous to clk.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out, MSB first.
- miso_oe  output  1  high while the slave drives miso (READ data phase).
- busy  output  1  synchronised, inverted cs_n (transaction active).
- cmd_err  output  1  one-clk pulse when a completed opcode byte is not supported.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=CMD; miso=0, miso_oe=0, busy=0, cmd_err=0.
  - Bit counters, shift register and address register are cleared.
  - Memory contents are NOT cleared.
  - Reset mid-transaction aborts it; a pending partial write byte is discarded.
- Sampling: cs_n, sck and mosi each pass through SYNC_STAGES flops. Edges are detected on synchronised sck by comparison with its previous value; mosi is taken from the same synchroniser depth.
- Rising SCK edge with cs_n low: shift the rx register left, inserting mosi; the 3-bit bit counter increments.
- Falling SCK edge with cs_n low: transmit logic (READ only).
- States:
  - CMD: after 8 bits, latch the opcode.
    - 0x03 -> ADDR.
    - 0x02 -> ADDR.
    - Otherwise pulse cmd_err for one clk and go to IGNORE.
  - ADDR: collect ADDR_BYTES*8 bits MSB first into addr. Effective index = addr mod MEM_BYTES (low log2(MEM_BYTES) bits). On the final address bit go to RDATA or WDATA.
  - RDATA:
    - On entry: tx_byte <= mem[index], tx_cnt=0.
    - Each falling edge: miso <= tx_byte[7-tx_cnt], miso_oe=1, tx_cnt++.
    - When tx_cnt wraps 7->0: index <= index+1 and tx_byte <= mem[index+1].
    - mosi is ignored in this state.
  - WDATA: on every 8th rising edge, mem[index] <= received byte, then index <= index+1.
  - IGNORE: sink all bits; miso=0, miso_oe=0; leave only on cs_n high.
- Index arithmetic: index wraps from MEM_BYTES-1 to 0 in both read and write bursts, with no error.
- Synchronised cs_n rising, from any state:
  - Return to CMD; miso=0, miso_oe=0 on the same clk.
  - Clear bit counters; discard any partial write byte (no memory update).
- Synchronised cs_n falling: busy=1. The first rising SCK edge after it is bit 7 of the opcode.
- Simultaneous events:
  - If a cs_n rise and an SCK edge are detected on the same clk, the cs_n rise wins; the SCK edge is ignored.
  - If rst coincides with anything, rst wins.
- Latency: miso changes SYNC_STAGES+1 clk after the falling SCK edge at the pin. With clk >= 8x sck, data is stable before the next rising edge.
- A WRITE followed by a READ of the same address in a later transaction returns the written data.

Optional Feature:
- Macro: SPI_RAM_FAST_READ_EN.
- Defined: opcode 0x0B (FAST READ) is accepted.
  - ADDR is followed by a DUMMY state of 8 SCK cycles. mosi is ignored and miso=0, miso_oe=0 throughout.
  - DUMMY then enters RDATA exactly as for 0x03.
- Not defined: 0x0B is unsupported; it pulses cmd_err and enters IGNORE.

Test Plan:
- Reset and idle: assert rst for 3 clk with cs_n=1 -> miso=0, miso_oe=0, busy=0, cmd_err=0. Memory pre-loaded by the bench is unchanged.
- Write then read (ADDR_BYTES=2):
  - Write: cs_n low, send 02 00 10 A5 3C, cs_n high -> mem[0x10]=A5, mem[0x11]=3C.
  - Read: send 03 00 10, then clock 16 bits -> miso returns A5 then 3C; miso_oe=1 during data only.
- Wrap-around (MEM_BYTES=256): write 02 00 FF 11 22 -> mem[0xFF]=11, mem[0x00]=22. Reading 03 00 FF for 2 bytes returns 11 22.
- Abort mid-byte: send 02 00 20 then 5 bits of 0xFF, raise cs_n -> mem[0x20] unchanged; the next transaction decodes normally.
- Bad opcode: send 0x9F then 16 bits -> cmd_err high for exactly 1 clk after bit 8; miso stays 0; busy drops on cs_n high. With SPI_RAM_FAST_READ_EN defined: 0B 00 10 + 8 dummy clocks -> A5 on miso; undefined -> cmd_err pulse.
- rst mid-read: assert rst after 4 data bits of 03 00 10 -> miso=0, miso_oe=0 next clk; memory unchanged; the next read of 0x10 returns A5.

Source files
------------

// File: rtl/spi_ram_slave.sv
`timescale 1ns/1ps
// SPI mode-0 RAM slave oversampled in clk: miso follows the SCK-fall pin edge by SYNC_STAGES+1 clk; no backpressure.
// Optional: define SPI_RAM_FAST_READ_EN to accept FAST READ (0x0B) with one dummy byte ahead of the data.
module spi_ram_slave #(
    parameter int MEM_BYTES   = 256,
    parameter int ADDR_BYTES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic busy,
    output logic cmd_err
);
    localparam int AW = (MEM_BYTES > 2) ? $clog2(MEM_BYTES) : 1;
    localparam logic [4:0] ALAST = 5'(ADDR_BYTES * 8 - 1);

    typedef enum logic [2:0] {
        ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_rise, sck_rise, sck_fall;

    state_t      state_q, state_d, after_q, after_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [4:0]  abit_cnt_q, abit_cnt_d;
    logic [7:0]  rx_q, rx_d, tx_byte_q, tx_byte_d;
    logic [AW-1:0] addr_q, addr_d;
    logic        miso_q, miso_d, oe_q, oe_d, err_q, err_d, busy_q;
    logic        mem_we;
    logic [7:0]  mem_q [MEM_BYTES];

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // A cs_n rise forces cs_s high, which already masks any SCK edge on the same clk.
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign sck_rise = ~cs_s & sck_s & ~sck_prev_q;
    assign sck_fall = ~cs_s & ~sck_s & sck_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        after_d    = after_q;
        bit_cnt_d  = bit_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        abit_cnt_d = abit_cnt_q;
        rx_d       = rx_q;
        tx_byte_d  = tx_byte_q;
        addr_d     = addr_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        if (cs_rise) begin
            state_d    = ST_CMD;
            bit_cnt_d  = 3'd0;
            tx_cnt_d   = 3'd0;
            abit_cnt_d = 5'd0;
            rx_d       = 8'd0;
            addr_d     = '0;
            miso_d     = 1'b0;
            oe_d       = 1'b0;
        end else if (sck_rise) begin
            rx_d      = {rx_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                ST_CMD: begin
                    if (bit_cnt_q == 3'd7) begin
                        case (rx_d)
                            8'h03: begin state_d = ST_ADDR; after_d = ST_RDATA; end
                            8'h02: begin state_d = ST_ADDR; after_d = ST_WDATA; end
`ifdef SPI_RAM_FAST_READ_EN
                            8'h0B: begin state_d = ST_ADDR; after_d = ST_DUMMY; end
`endif
                            default: begin state_d = ST_IGNORE; err_d = 1'b1; end
                        endcase
                    end
                end
                ST_ADDR: begin
                    // Only the low AW bits are kept: the index is the address modulo MEM_BYTES.
                    addr_d     = AW'({addr_q, mosi_s});
                    abit_cnt_d = abit_cnt_q + 5'd1;
                    if (abit_cnt_q == ALAST) begin
                        state_d    = after_q;
                        abit_cnt_d = 5'd0;
                        tx_byte_d  = mem_q[addr_d];
                        tx_cnt_d   = 3'd0;
                    end
                end
                ST_DUMMY: begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = ST_RDATA;
                        tx_byte_d = mem_q[addr_q];
                        tx_cnt_d  = 3'd0;
                    end
                end
                ST_WDATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        mem_we = 1'b1;
                        addr_d = addr_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end else if (sck_fall && state_q == ST_RDATA) begin
            miso_d   = tx_byte_q[3'd7 - tx_cnt_q];
            oe_d     = 1'b1;
            tx_cnt_d = tx_cnt_q + 3'd1;
            if (tx_cnt_q == 3'd7) begin
                addr_d    = addr_q + AW'(1);
                tx_byte_d = mem_q[addr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CMD;
            after_q    <= ST_RDATA;
            bit_cnt_q  <= 3'd0;
            tx_cnt_q   <= 3'd0;
            abit_cnt_q <= 5'd0;
            rx_q       <= 8'd0;
            tx_byte_q  <= 8'd0;
            addr_q     <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            after_q    <= after_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            abit_cnt_q <= abit_cnt_d;
            rx_q       <= rx_d;
            tx_byte_q  <= tx_byte_d;
            addr_q     <= addr_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            err_q      <= err_d;
            busy_q     <= ~cs_s;
        end
    end

    // Memory contents survive reset; reset only blocks a write in flight.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr_q] <= rx_d;
        end
    end

    assign miso    = miso_q;
    assign miso_oe = oe_q;
    assign busy    = busy_q;
    assign cmd_err = err_q;
endmodule

// File: tb/tb_spi_ram_slave.sv
`timescale 1ns/1ps
// Bench for spi_ram_slave: table of write/read transactions with a read-data scoreboard, plus corner sequences.
module tb_spi_ram_slave;
    localparam int HALF = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs_n = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic miso, miso_oe, busy, cmd_err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nrd;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    spi_ram_slave #(.MEM_BYTES(256), .ADDR_BYTES(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cmd_err === 1'b1) err_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx,
                            output logic all_oe, output logic any_oe);
        logic [7:0] r;
        logic a, o;
        r = 8'd0; a = 1'b1; o = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #HALF;
            r[i] = miso;
            a = a & miso_oe;
            o = o | miso_oe;
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
        end
        rx = r; all_oe = a; any_oe = o;
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        cs_n = 1'b1;
        #(4*HALF);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [7:0] a, input string tag);
        logic [7:0] r;
        logic all_oe, any_oe, seen;
        seen = 1'b0;
        spi_byte(op, r, all_oe, any_oe);    seen = seen | any_oe;
        spi_byte(8'h00, r, all_oe, any_oe); seen = seen | any_oe;
        spi_byte(a, r, all_oe, any_oe);     seen = seen | any_oe;
        check({tag, " hdr_oe"}, {31'd0, seen}, 32'd0);
    endtask

    task automatic read_bytes(input int n, input string tag);
        logic [7:0] r, e;
        logic all_oe, any_oe;
        for (int k = 0; k < n; k++) begin
            spi_byte(8'h00, r, all_oe, any_oe);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL %s: got %0h with empty scoreboard", tag, r);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("%s byte%0d", tag, k), {24'd0, r}, {24'd0, e});
                check($sformatf("%s oe%0d", tag, k), {31'd0, all_oe}, 32'd1);
            end
        end
    endtask

    initial begin
        vec_t tbl[5];
        logic [7:0] r;
        logic all_oe, any_oe;
        logic [3:0] nib;
        int e0;

        tbl[0] = '{1'b1, 8'h10, 8'hA5, 8'h3C, 2, 8'hA5, 8'h3C};
        tbl[1] = '{1'b1, 8'hFF, 8'h11, 8'h22, 2, 8'h11, 8'h22};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 8'h00, 1, 8'h22, 8'h00};
        tbl[3] = '{1'b1, 8'h20, 8'h77, 8'h88, 2, 8'h77, 8'h88};
        tbl[4] = '{1'b0, 8'h11, 8'h00, 8'h00, 1, 8'h3C, 8'h00};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst miso", {31'd0, miso}, 32'd0);
        check("rst miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst cmd_err", {31'd0, cmd_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            if (tbl[v].wr) begin
                cs_start();
                send_hdr(8'h02, tbl[v].addr, $sformatf("wr%0d", v));
                spi_byte(tbl[v].d0, r, all_oe, any_oe);
                spi_byte(tbl[v].d1, r, all_oe, any_oe);
                cs_end();
            end
            exp_q.push_back(tbl[v].e0);
            if (tbl[v].nrd == 2) exp_q.push_back(tbl[v].e1);
            cs_start();
            send_hdr(8'h03, tbl[v].addr, $sformatf("rd%0d", v));
            read_bytes(tbl[v].nrd, $sformatf("rd%0d", v));
            cs_end();
        end

        // Abort a write after 5 bits of its first data byte.
        cs_start();
        send_hdr(8'h02, 8'h20, "abort");
        for (int i = 0; i < 5; i++) begin
            mosi = 1'b1; #HALF; sck = 1'b1; #HALF; sck = 1'b0;
        end
        cs_end();
        exp_q.push_back(8'h77);
        cs_start();
        send_hdr(8'h03, 8'h20, "after_abort");
        read_bytes(1, "after_abort");
        cs_end();

        // Unsupported opcode.
        e0 = err_cnt;
        cs_start();
        spi_byte(8'h9F, r, all_oe, any_oe);
        check("bad cmd_err after op", err_cnt - e0, 32'd1);
        check("bad busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            spi_byte(8'hFF, r, all_oe, any_oe);
            check($sformatf("bad miso%0d", k), {24'd0, r}, 32'd0);
            check($sformatf("bad oe%0d", k), {31'd0, any_oe}, 32'd0);
        end
        cs_end();
        check("bad cmd_err pulses", err_cnt - e0, 32'd1);
        check("bad busy end", {31'd0, busy}, 32'd0);

        // FAST READ: accepted only when the option is built in.
        e0 = err_cnt;
        cs_start();
        send_hdr(8'h0B, 8'h10, "fast");
        spi_byte(8'h00, r, all_oe, any_oe);
        check("fast dummy oe", {31'd0, any_oe}, 32'd0);
`ifdef SPI_RAM_FAST_READ_EN
        exp_q.push_back(8'hA5);
        read_bytes(1, "fast");
        check("fast cmd_err", err_cnt - e0, 32'd0);
`else
        spi_byte(8'h00, r, all_oe, any_oe);
        check("fast miso", {24'd0, r}, 32'd0);
        check("fast cmd_err", err_cnt - e0, 32'd1);
`endif
        cs_end();

        // Reset in the middle of a read data byte.
        cs_start();
        send_hdr(8'h03, 8'h10, "rstrd");
        nib = 4'd0;
        for (int i = 0; i < 4; i++) begin
            mosi = 1'b0; #HALF; nib = {nib[2:0], miso}; sck = 1'b1; #HALF; sck = 1'b0;
        end
        #HALF;
        check("rstrd nibble", {28'd0, nib}, 32'hA);
        check("rstrd oe before", {31'd0, miso_oe}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstrd miso", {31'd0, miso}, 32'd0);
        check("rstrd oe", {31'd0, miso_oe}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cs_end();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        cs_start();
        send_hdr(8'h03, 8'h10, "post_rst");
        read_bytes(2, "post_rst");
        cs_end();

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
